// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - single-outstanding data memory with wait states and byte-lane access
//
// Purpose:
//   Word-organised data memory serving RV32-style loads and stores one at a
//   time. Each accepted request waits LATENCY cycles, then accesses the array
//   and presents a response that is held until it is consumed.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words of storage
//   LATENCY      wait cycles (0..15) before each array access
//
// Ports:
//   CLK          clock, all state changes on rising edge
//   RST          synchronous active-high reset
//   req_valid    request present
//   req_ready    request acceptable (only in IDLE)
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   req_ctrl     funct3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   resp_valid   response present
//   resp_ready   response consumed
//   resp_rdata   load result (0 for stores and errors)
//   resp_err     request failed
//
// Configuration:
//   DMEM_RESP_ERR_EN  when defined, illegal ctrl, misaligned, out-of-range and
//                     unsigned-store requests are answered with resp_err=1.
//                     When undefined, addresses are force-aligned, the word
//                     index wraps, bad ctrl acts as W and BU/HU stores act as B/H.
`timescale 1ns/1ps

module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    // Captured request, already normalised to size/sign and aligned address
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Request decode on the live inputs, used at the accept edge
    logic        req_bad_ctrl;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr_al;
    logic        req_err;

    always_comb begin
        req_bad_ctrl = (req_ctrl == 3'b011) || (req_ctrl[2:1] == 2'b11);
        req_size     = req_bad_ctrl ? SZ_W : req_ctrl[1:0];
        req_uns      = req_ctrl[2] & ~req_bad_ctrl;
        req_addr_al  = req_addr;
        if (req_size == SZ_H) begin
            req_addr_al[0] = 1'b0;
        end else if (req_size == SZ_W) begin
            req_addr_al[1:0] = 2'b00;
        end
`ifdef DMEM_RESP_ERR_EN
        req_err = req_bad_ctrl
               || ((req_size == SZ_H) && req_addr[0])
               || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
               || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS))
               || (req_ctrl[2] && req_we);
`else
        req_err = 1'b0;
`endif
    end

    // Array access datapath from the captured request
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_d;
    logic [31:0]   rdata_d;
    logic [3:0]    be_d;
    logic [31:0]   wd_d;
    logic          do_access;

    always_comb begin
        // Out-of-range indices only reach here when errors are disabled,
        // where wrapping is the intended behaviour.
        word_idx = AW'({2'b00, addr_q[31:2]} % 32'(DEPTH_WORDS));
        lane     = addr_q[1:0];
        rd_word  = mem_q[word_idx];
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

        case (size_q)
            SZ_B:    load_d = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_H:    load_d = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_d = rd_word;
        endcase
        rdata_d = we_q ? 32'd0 : load_d;

        // Store data is replicated across lanes; the byte enables pick the target
        case (size_q)
            SZ_B: begin
                be_d = 4'b0001 << lane;
                wd_d = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                be_d = lane[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{wdata_q[15:0]}};
            end
            default: begin
                be_d = 4'b1111;
                wd_d = wdata_q;
            end
        endcase

        // Reset on the access edge aborts the store
        do_access = (state_q == WAIT) && (cnt_q == 4'd0) && !RST;
    end

    // Storage is never cleared by reset
    always_ff @(posedge CLK) begin
        if (do_access && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wd_d[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        uns_q   <= req_uns;
                        size_q  <= req_size;
                        addr_q  <= req_addr_al;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - scoreboard testbench for dmem_resp
`timescale 1ns/1ps

module tb_dmem_resp;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int L1    = LAT + 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_ctrl = 3'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ctrl  (req_ctrl),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic we, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd_exp, input logic err_exp,
                         input int lat_exp, input int hold);
        exp_t        e;
        int          n;
        int          lat;
        logic [31:0] held;
        e.rdata = rd_exp;
        e.err   = err_exp;
        e.lat   = lat_exp;
        sb_q.push_back(e);

        @(negedge CLK);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge CLK);
        #1 req_valid = 1'b0;

        // Edges after the accept edge until the response is seen
        lat = 0;
        @(negedge CLK);
        while (!resp_valid && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        held = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "/hold_rdata"}, resp_rdata, held);
            check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
        end

        e = sb_q.pop_front();
        check({tag, "/lat"}, 32'(lat), 32'(e.lat));
        check({tag, "/rdata"}, resp_rdata, e.rdata);
        check({tag, "/err"}, 32'(resp_err), 32'(e.err));

        resp_ready = 1'b1;
        @(posedge CLK);
        #1 resp_ready = 1'b0;
        @(negedge CLK);
        check({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, "/idle_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst/valid", 32'(resp_valid), 32'd0);
        check("rst/ready", 32'(req_ready), 32'd1);
        check("rst/rdata", resp_rdata, 32'd0);
        check("rst/err", 32'(resp_err), 32'd0);

        issue("sw10",  1'b1, 3'b010, 32'h10, 32'h8000_00F0, 32'd0,         1'b0, L1, 0);
        issue("lw10",  1'b0, 3'b010, 32'h10, 32'd0,         32'h8000_00F0, 1'b0, L1, 5);
        issue("lb13",  1'b0, 3'b000, 32'h13, 32'd0,         32'hFFFF_FF80, 1'b0, L1, 0);
        issue("lbu13", 1'b0, 3'b100, 32'h13, 32'd0,         32'h0000_0080, 1'b0, L1, 0);
        issue("lh12",  1'b0, 3'b001, 32'h12, 32'd0,         32'hFFFF_8000, 1'b0, L1, 0);
        issue("lhu10", 1'b0, 3'b101, 32'h10, 32'd0,         32'h0000_00F0, 1'b0, L1, 0);
        issue("sb11",  1'b1, 3'b000, 32'h11, 32'h0000_00AB, 32'd0,         1'b0, L1, 0);
        issue("lw10b", 1'b0, 3'b010, 32'h10, 32'd0,         32'h8000_ABF0, 1'b0, L1, 0);
        issue("sw20",  1'b1, 3'b010, 32'h20, 32'hCAFE_BABE, 32'd0,         1'b0, L1, 0);

        // Store aborted by reset during its first wait cycle
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_ctrl  = 3'b010;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("abort/valid", 32'(resp_valid), 32'd0);
        check("abort/ready", 32'(req_ready), 32'd1);
        issue("lw20",  1'b0, 3'b010, 32'h20, 32'd0,         32'hCAFE_BABE, 1'b0, L1, 0);

        issue("sh22",  1'b1, 3'b001, 32'h22, 32'hFFFF_1234, 32'd0,         1'b0, L1, 0);
        issue("lw20b", 1'b0, 3'b010, 32'h20, 32'd0,         32'h1234_BABE, 1'b0, L1, 0);
        issue("lh22",  1'b0, 3'b001, 32'h22, 32'd0,         32'h0000_1234, 1'b0, L1, 0);
        issue("sw00",  1'b1, 3'b010, 32'h0,  32'h1111_1111, 32'd0,         1'b0, L1, 0);

`ifdef DMEM_RESP_ERR_EN
        issue("lw12e",  1'b0, 3'b010, 32'h12,   32'd0,         32'd0,         1'b1, 0, 0);
        issue("lh11e",  1'b0, 3'b001, 32'h11,   32'd0,         32'd0,         1'b1, 0, 0);
        issue("swoor",  1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'd0,         1'b1, 0, 0);
        issue("lw00",   1'b0, 3'b010, 32'h0,    32'd0,         32'h1111_1111, 1'b0, L1, 0);
        issue("bad111", 1'b0, 3'b111, 32'h10,   32'd0,         32'd0,         1'b1, 0, 0);
        issue("sbu13",  1'b1, 3'b100, 32'h13,   32'h0000_005A, 32'd0,         1'b1, 0, 0);
        issue("lw10c",  1'b0, 3'b010, 32'h10,   32'd0,         32'h8000_ABF0, 1'b0, L1, 0);
`else
        issue("lw12a",  1'b0, 3'b010, 32'h12,   32'd0,         32'h8000_ABF0, 1'b0, L1, 0);
        issue("swwrap", 1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 32'd0,         1'b0, L1, 0);
        issue("lw00",   1'b0, 3'b010, 32'h0,    32'd0,         32'hDEAD_BEEF, 1'b0, L1, 0);
        issue("bad111", 1'b0, 3'b111, 32'h10,   32'd0,         32'h8000_ABF0, 1'b0, L1, 0);
        issue("sbu13",  1'b1, 3'b100, 32'h13,   32'h0000_005A, 32'd0,         1'b0, L1, 0);
        issue("lw10c",  1'b0, 3'b010, 32'h10,   32'd0,         32'h5A00_ABF0, 1'b0, L1, 0);
        issue("lh11a",  1'b0, 3'b001, 32'h11,   32'd0,         32'hFFFF_ABF0, 1'b0, L1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
